// File: rtl/shift_add_mul.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier controller.
// Drives an external WIDTH-bit ripple-carry adder and folds its sum/carry
// back into the accumulator once per cycle, LSB of the multiplier first.
module shift_add_mul #(
  parameter int unsigned WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_ci,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_co
);

  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   product_d;
  logic                in_ready_d;
  logic                out_valid_d;
  logic [PROD_W-1:0]   shifted;

  // Adder result plus carry, shifted right one place together with Q.
  // The carry becomes the accumulator MSB, so nothing is ever lost.
  assign shifted = {add_co, add_s, q_q[WIDTH-1:1]};

  // Adder operands: only driven while an operation is in flight.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_a = acc_q;
      add_b = q_q[0] ? m_q : '0;
    end
  end

  // Next-state, datapath next values and registered handshake outputs.
  always_comb begin
    state_d   = state;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          m_d     = in_a;
          q_d     = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        {acc_d, q_d} = shifted;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = shifted;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product   <= product_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul with a behavioural adder and a*b reference.
module tb_shift_add_mul;

  localparam int unsigned W = 6;
  localparam int unsigned TMO = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    product;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_ci;
  logic [W-1:0]      add_s;
  logic              add_co;
  logic [W:0]        sum;

  int vectors = 0;
  int miscompares = 0;
  int accepts = 0;
  int results = 0;
  int lat;
  bit co_seen;
  logic [W-1:0] rec_b [W];

  always #5 clk = ~clk;

  // External ripple-carry adder, modelled behaviourally.
  assign sum    = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};
  assign add_s  = sum[W-1:0];
  assign add_co = sum[W];

  shift_add_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co)
  );

  // Handshake counters for the one-result-per-accept check.
  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) accepts++;
      if (out_valid && out_ready) results++;
    end
  end

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return (2*W)'(p);
  endfunction

  // Wait for in_ready, present one pair, return at the negedge after acceptance.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL start_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
  endtask

  // Count edges until out_valid, recording the adder B operand for each RUN cycle.
  task automatic wait_result(input bit noise);
    lat = 0; co_seen = 1'b0;
    while (!out_valid && lat < int'(TMO)) begin
      if (lat < int'(W)) rec_b[lat] = add_b;
      if (add_co) co_seen = 1'b1;
      if (noise) begin
        in_valid = 1'($urandom); in_a = W'($urandom); in_b = W'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      vectors++; miscompares++;
      $display("FAIL result_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic finish_op;
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, product, add_a, add_b, add_ci} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b prod=%0d a=%0d b=%0d ci=%0b, required all 0",
               in_ready, out_valid, product, add_a, add_b, add_ci);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%0b, required 1", in_ready);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] a, b;
    a = 6'd5; b = 6'd7;
    start_op(a, b);
    wait_result(1'b0);
    vectors++;
    if (lat !== int'(W)) begin
      miscompares++;
      $display("FAIL basic_latency: %0d edges, required %0d", lat, W);
    end
    vectors++;
    if (product !== 12'd35) begin
      miscompares++;
      $display("FAIL basic_product: %0d, required 35", product);
    end
    for (int i = 0; i < int'(W); i++) begin
      vectors++;
      if (rec_b[i] !== (b[i] ? a : '0)) begin
        miscompares++;
        $display("FAIL basic_add_b[%0d]: %0d, required %0d", i, rec_b[i], b[i] ? a : '0);
      end
    end
    finish_op();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_return_idle: vld=%0b rdy=%0b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_max;
    start_op(6'd63, 6'd63);
    wait_result(1'b0);
    vectors++;
    if (product !== 12'hF81) begin
      miscompares++;
      $display("FAIL max_product: %0d, required 3969", product);
    end
    vectors++;
    if (co_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL max_carry_seen: %0b, required 1", co_seen);
    end
    finish_op();
  endtask

  task automatic test_zero_operand;
    logic [W-1:0] as [4];
    logic [W-1:0] bs [4];
    as[0] = 6'd0;  bs[0] = 6'd63;
    as[1] = 6'd63; bs[1] = 6'd0;
    as[2] = W'($urandom); bs[2] = W'($urandom);
    as[3] = W'($urandom); bs[3] = 6'b101010;
    for (int k = 0; k < 4; k++) begin
      start_op(as[k], bs[k]);
      wait_result(1'b0);
      vectors++;
      if (product !== ref_mul(as[k], bs[k])) begin
        miscompares++;
        $display("FAIL zero_product: %0d*%0d gave %0d, required %0d", as[k], bs[k], product, ref_mul(as[k], bs[k]));
      end
      for (int i = 0; i < int'(W); i++) begin
        vectors++;
        if (rec_b[i] !== (bs[k][i] ? as[k] : '0)) begin
          miscompares++;
          $display("FAIL zero_add_b[%0d]: %0d, required %0d", i, rec_b[i], bs[k][i] ? as[k] : '0);
        end
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp;
    a = W'($urandom); b = W'($urandom);
    exp = ref_mul(a, b);
    start_op(a, b);
    wait_result(1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (product !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: prod=%0d vld=%0b rdy=%0b, required %0d/1/0",
                 i, product, out_valid, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: rdy=%0b vld=%0b, required 1/0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    start_op(6'd2, 6'd3);
    wait_result(1'b0);
    vectors++;
    if (product !== 12'd6) begin
      miscompares++;
      $display("FAIL hold_next_product: %0d, required 6", product);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_run;
    int spurious;
    start_op(6'd9, 6'd9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({out_valid, product, add_a, add_b, add_ci, in_ready} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: vld=%0b prod=%0d a=%0d b=%0d ci=%0b rdy=%0b, required all 0",
               out_valid, product, add_a, add_b, add_ci, in_ready);
    end
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    vectors++;
    if (spurious !== 0) begin
      miscompares++;
      $display("FAIL abort_no_result: %0d valid cycles, required 0", spurious);
    end
    start_op(6'd1, 6'd1);
    wait_result(1'b0);
    vectors++;
    if (product !== 12'd1) begin
      miscompares++;
      $display("FAIL abort_next_product: %0d, required 1", product);
    end
    finish_op();
  endtask

  task automatic test_back_to_back;
    int n_ops, acc0, res0, bad;
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp;
    n_ops = 1000; bad = 0;
    acc0 = accepts; res0 = results;
    for (int k = 0; k < n_ops; k++) begin
      a = W'($urandom); b = W'($urandom);
      exp = ref_mul(a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(a, b);
      wait_result(1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      vectors++;
      if (product !== exp || out_valid !== 1'b1) begin
        miscompares++;
        if (bad < 10) $display("FAIL random_product: %0d*%0d gave %0d vld=%0b, required %0d", a, b, product, out_valid, exp);
        bad++;
      end
      finish_op();
    end
    vectors++;
    if (accepts - acc0 !== n_ops || results - res0 !== n_ops) begin
      miscompares++;
      $display("FAIL random_counts: accepts=%0d results=%0d, required %0d each", accepts - acc0, results - res0, n_ops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_operand();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
